// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: geometry and the hard-wired zero index.
package reg_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_IDX = 0;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-index force, write-first bypass, array select.
// Latency 0; no backpressure.
module rf_read_port #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   raddr,
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
    output logic [DATA_W-1:0]                   rdata
);
    import reg_file_pkg::ZERO_IDX;

    logic rd_zero;
    logic bypass;

    assign rd_zero = (raddr == ADDR_W'(ZERO_IDX));
    assign bypass  = we && (waddr != ADDR_W'(ZERO_IDX)) && (waddr == raddr);

    always_comb begin
        rdata = '0;
        // Reset and index 0 both force zero, ahead of the bypass path.
        if (rst || rd_zero) begin
            rdata = '0;
        end else if (bypass) begin
            rdata = wdata;
        end else begin
            rdata = regs[raddr];
        end
    end
endmodule

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file, two operand read ports plus a debug port, write counter.
// Reads are zero-latency with write-first bypass; writes commit on clk; no backpressure.
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);
    import reg_file_pkg::ZERO_IDX;

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            commit;

    assign commit = we && (waddr != ADDR_W'(ZERO_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs     <= '0;
            wr_count <= '0;
        end else if (commit) begin
            regs[waddr] <= wdata;
            if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .rst   (rst),
        .raddr (raddr_a),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs),
        .rdata (rdata_a)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .rst   (rst),
        .raddr (raddr_b),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs),
        .rdata (rdata_b)
    );

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
        .rst   (rst),
        .raddr (dbg_addr),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs),
        .rdata (dbg_data)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios followed by random traffic, checked against an array model of the register file.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [15:0] wr_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [32];
    int          mcount;

    reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // What a reader should see right now given the model and the live write request.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (we && waddr != 5'd0 && waddr == a) return wdata;
        return mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcount = 0;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
        we = w; waddr = wa; wdata = wd;
        raddr_a = ra; raddr_b = rb; dbg_addr = rd;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".a"},   rdata_a,             exp_rd(raddr_a));
        chk({tag, ".b"},   rdata_b,             exp_rd(raddr_b));
        chk({tag, ".dbg"}, dbg_data,            exp_rd(dbg_addr));
        chk({tag, ".cnt"}, {16'h0, wr_count},   mcount);
    endtask

    // Advance one clock: model commits what the DUT saw at the edge, return at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (we && waddr != 5'd0) begin
            mdl[waddr] = wdata;
            if (mcount < 65535) mcount++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        model_clear();
        repeat (2) @(negedge clk);

        // Writes and bypass are both suppressed while reset is held.
        drive(1'b1, 5'd4, 32'hCAFEF00D, 5'd4, 5'd4, 5'd4);
        check_all("rst_hold");
        tick();
        check_all("rst_hold_edge");

        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
            #1;
            chk("reset_sweep.a",   rdata_a,  32'h0);
            chk("reset_sweep.b",   rdata_b,  32'h0);
            chk("reset_sweep.dbg", dbg_data, 32'h0);
        end
        chk("reset_cnt", {16'h0, wr_count}, 32'h0);

        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0);
        #1;
        chk("basic_write.a",   rdata_a,            32'hDEADBEEF);
        chk("basic_write.cnt", {16'h0, wr_count},  32'd1);

        drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("zero_reg.b",   rdata_b,           32'h0);
        chk("zero_reg.cnt", {16'h0, wr_count}, 32'd1);

        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd8, 5'd7);
        #1;
        chk("bypass.a",   rdata_a,  32'hA5A5A5A5);
        chk("bypass.b",   rdata_b,  32'h0);
        chk("bypass.dbg", dbg_data, 32'hA5A5A5A5);
        tick();

        drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 32'h99999999, 5'd3, 5'd9, 5'd3);
        #1;
        chk("mid_rst_pre.a", rdata_a, 32'h1);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("mid_rst.a",   rdata_a,           32'h0);
        chk("mid_rst.b",   rdata_b,           32'h0);
        chk("mid_rst.cnt", {16'h0, wr_count}, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 5'd7);
        check_all("after_rst");
        chk("lost_write", rdata_a, 32'h0);

        // Fill 1..31 with their own index; the first edge after reset must already commit.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 5'd0);
            tick();
            if (i == 1) begin
                drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd0);
                #1;
                chk("first_write.a",   rdata_a,           32'd1);
                chk("first_write.cnt", {16'h0, wr_count}, 32'd1);
            end
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 5'(i));
            #1;
            chk("fill.a",   rdata_a,  32'(i));
            chk("fill.b",   rdata_b,  32'(i));
            chk("fill.dbg", dbg_data, 32'(i));
        end
        chk("fill.cnt", {16'h0, wr_count}, 32'd31);

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) raddr_a = waddr;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                model_clear();
            end else begin
                rst = 1'b0;
            end
            check_all("rand");
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check_all("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, meaning register address width (2**ADDR_W registers).
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all writes occur on its rising edge.
REQ-004 The block SHALL provide port rst, input, 1, reset, which is asynchronous and active-high.
REQ-005 The block SHALL provide port we, input, 1, write enable.
REQ-006 The block SHALL provide port waddr, input, ADDR_W, write register index, driven by the upstream 5-bit destination-select mux output.
REQ-007 The block SHALL provide port wdata, input, DATA_W, write data.
REQ-008 The block SHALL provide ports raddr_a and raddr_b, input, ADDR_W, read indices for operand ports A and B.
REQ-009 The block SHALL provide ports rdata_a and rdata_b, output, DATA_W, read data for ports A and B.
REQ-010 The block SHALL provide port dbg_addr, input, ADDR_W, debug/display read index.
REQ-011 The block SHALL provide port dbg_data, output, DATA_W, debug read data.
REQ-012 The block SHALL provide port wr_count, output, 16, count of committed writes.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-014 A write SHALL commit on a rising clk edge when we=1, rst=0 and waddr!=0.
REQ-015 Writes to index 0 SHALL be discarded; register 0 reads 0 always.
REQ-016 All three read ports SHALL be combinational; zero-cycle latency from address to data.
REQ-017 Read bypass: when we=1, waddr!=0 and waddr equals a port's read address, that port SHALL return wdata in the same cycle (write-first).
REQ-018 A read of index 0 SHALL return 0 regardless of we/waddr/wdata.
REQ-019 Simultaneous reads of the same index on A, B and debug SHALL return identical data.
REQ-020 wr_count SHALL increment by 1 per committed write (REQ-014 only), saturating at 16'hFFFF.
REQ-021 we=1 with waddr=0 SHALL NOT increment wr_count.
REQ-022 No X SHALL propagate to outputs after the first reset.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, clear all registers and wr_count to 0.
REQ-024 While rst=1, no write SHALL commit, and all read outputs SHALL be 0; bypass is suppressed.
REQ-025 A reset asserted mid-operation SHALL discard any write pending in that cycle.
REQ-026 After rst deasserts, the first write SHALL commit on the first rising edge with we=1.

Structure
REQ-027 A shared package SHALL hold DATA_W, ADDR_W, NUM_REGS and the constant ZERO_IDX=0.
REQ-028 One sub-module, rf_read_port, SHALL implement the zero-index check, bypass compare and array select, and SHALL be instantiated three times (A, B, debug).
REQ-029 The storage array and wr_count SHALL reside in reg_file itself.

Verification
REQ-030 Reset scenario: rst=1 -> rst=0, read all 32 indices -> every read returns 0, wr_count=0.
REQ-031 Basic write scenario: write 0xDEADBEEF to index 5, then read raddr_a=5 on the next cycle -> rdata_a=0xDEADBEEF, wr_count=1.
REQ-032 Zero-register scenario: write 0x12345678 to index 0, then read raddr_b=0 -> rdata_b=0, wr_count unchanged.
REQ-033 Bypass scenario: in the same cycle apply we=1, waddr=7, wdata=0xA5A5A5A5 and raddr_a=7 -> rdata_a=0xA5A5A5A5 before the edge; raddr_b=8 is unaffected.
REQ-034 Async-reset-mid-operation scenario: write index 3=0x1 and commit it, then assert rst between edges -> rdata for index 3 goes to 0 without a clock edge; a write pending in that cycle is lost.
REQ-035 Dual-port/debug scenario: fill indices 1-31 with their index values, then sweep raddr_a, raddr_b and dbg_addr -> each returns its index value, and wr_count=31.
